// File: rtl/decode_issue_ctrl_if.sv
// Fetch-side, execute-hazard and issue-side signals of the decode issue queue.
interface decode_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        ex_valid;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    modport slave (
        input  in_valid, in_instr, in_pc, ex_valid, ex_is_load, ex_rd, out_ready,
        output in_ready, out_valid, out_instr, out_pc
    );
    modport master (
        output in_valid, in_instr, in_pc, ex_valid, ex_is_load, ex_rd, out_ready,
        input  in_ready, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Decode-stage instruction queue: circular buffer feeding the decoder, with
// load-use hazard hold, flush discard and a saturating hazard-stall counter.
module decode_issue_ctrl #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    decode_issue_ctrl_if.slave   bus,
    output logic [CNT_W-1:0]     occupancy,
    output logic [63:0]          stall_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    entry_t           head;
    logic             not_empty, hazard, uses_rs1, uses_rs2, push, pop;
    logic [6:0]       opcode;

    assign not_empty = (occupancy != '0);
    assign head      = mem[rd_ptr];
    assign opcode    = head.instr[6:0];

    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            7'b0110111, 7'b0010111, 7'b1101111: uses_rs1 = 1'b0;
            default: ;
        endcase
        case (opcode)
            7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011: uses_rs2 = 1'b1;
            default: ;
        endcase
    end

    // Hazard is evaluated on whatever sits at the head, valid or not; gated below.
    assign hazard = bus.ex_valid && bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                    ((uses_rs1 && head.instr[19:15] == bus.ex_rd) ||
                     (uses_rs2 && head.instr[24:20] == bus.ex_rd));

    assign bus.in_ready  = !flush && (occupancy < CNT_W'(DEPTH));
    assign bus.out_valid = !flush && not_empty && !hazard;
    assign bus.out_instr = not_empty ? head.instr : 32'd0;
    assign bus.out_pc    = not_empty ? head.pc    : 64'd0;

    assign push = bus.in_valid  && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{instr: bus.in_instr, pc: bus.in_pc};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            stall_cnt <= '0;
        end else begin
            if (not_empty && hazard && !flush && stall_cnt != '1)
                stall_cnt <= stall_cnt + 64'd1;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                occupancy <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   occupancy <= occupancy + CNT_W'(1);
                    2'b01:   occupancy <= occupancy - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl with hand-computed expectations.
module tb_decode_issue_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [2:0]  occupancy;
    logic [63:0] stall_cnt;
    int          n_chk = 0;
    int          n_err = 0;

    decode_issue_ctrl_if bus ();

    decode_issue_ctrl #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus.slave),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [63:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0;
        bus.ex_valid = 0; bus.ex_is_load = 0; bus.ex_rd = 0; bus.out_ready = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_occ", 64'(occupancy), 0);
        chk("rst_in_ready", 64'(bus.in_ready), 1);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_out_instr", 64'(bus.out_instr), 0);
        chk("rst_out_pc", bus.out_pc, 0);
        chk("rst_stall", stall_cnt, 0);

        // Single push / pop
        push(32'h00500093, 64'h8000_0000);
        #1;
        chk("t1_valid", 64'(bus.out_valid), 1);
        chk("t1_instr", 64'(bus.out_instr), 64'h00500093);
        chk("t1_pc", bus.out_pc, 64'h8000_0000);
        chk("t1_occ", 64'(occupancy), 1);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0; #1;
        chk("t1_occ_pop", 64'(occupancy), 0);
        chk("t1_valid_pop", 64'(bus.out_valid), 0);

        // Fill to full, then pop+push while full
        for (int i = 0; i < 4; i++) push(32'h00000013 | (32'(i) << 20), 64'h100 + 64'(4 * i));
        #1;
        chk("t2_occ_full", 64'(occupancy), 4);
        chk("t2_in_ready_full", 64'(bus.in_ready), 0);
        bus.in_valid = 1'b1; bus.in_instr = 32'hDEADBEEF; bus.in_pc = 64'hBAD;
        bus.out_ready = 1'b1; #1;
        chk("t2_in_ready_popfull", 64'(bus.in_ready), 0);
        chk("t2_out_valid_full", 64'(bus.out_valid), 1);
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; #1;
        chk("t2_occ_after", 64'(occupancy), 3);
        for (int i = 1; i < 4; i++) begin
            chk("t2_order_instr", 64'(bus.out_instr), 64'(32'h00000013 | (32'(i) << 20)));
            chk("t2_order_pc", bus.out_pc, 64'h100 + 64'(4 * i));
            bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0; #1;
        end
        chk("t2_drained", 64'(occupancy), 0);

        // Load-use hazard on ADD x3,x1,x2
        push(32'h002081B3, 64'h200);
        bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd2;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_hold", 64'(bus.out_valid), 0);
            tick();
        end
        #1;
        chk("t3_stall3", stall_cnt, 3);
        chk("t3_occ_held", 64'(occupancy), 1);
        bus.out_ready = 1'b0;
        bus.ex_rd = 5'd0; #1;
        chk("t3_rd0_issue", 64'(bus.out_valid), 1);
        bus.ex_rd = 5'd1; #1;
        chk("t3_rs1_hazard", 64'(bus.out_valid), 0);
        bus.ex_rd = 5'd2; bus.ex_is_load = 1'b0; #1;
        chk("t3_noload_issue", 64'(bus.out_valid), 1);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0; #1;
        chk("t3_popped", 64'(occupancy), 0);
        chk("t3_stall_kept", stall_cnt, 3);

        // LUI has no source regs; ADDI has no rs2
        bus.ex_is_load = 1'b1; bus.ex_rd = 5'd1;
        push(32'h000010B7, 64'h300);
        #1;
        chk("t4_lui_valid", 64'(bus.out_valid), 1);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        bus.ex_rd = 5'd2;
        push(32'h00208093, 64'h304);
        #1;
        chk("t4_addi_no_rs2", 64'(bus.out_valid), 1);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0; #1;
        chk("t4_stall_same", stall_cnt, 3);
        chk("t4_occ", 64'(occupancy), 0);
        bus.ex_valid = 1'b0; bus.ex_is_load = 1'b0; bus.ex_rd = 5'd0;

        // Flush with a concurrent push
        for (int i = 0; i < 3; i++) push(32'h11100013 + 32'(i), 64'h400 + 64'(i));
        flush = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'hCAFE0013; bus.in_pc = 64'h500;
        bus.out_ready = 1'b1; #1;
        chk("t5_in_ready", 64'(bus.in_ready), 0);
        chk("t5_out_valid", 64'(bus.out_valid), 0);
        tick();
        flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; #1;
        chk("t5_occ", 64'(occupancy), 0);
        chk("t5_out_instr", 64'(bus.out_instr), 0);
        chk("t5_out_valid_after", 64'(bus.out_valid), 0);

        // Streaming push+pop through pointer wrap
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = 32'hA000_0013 + 32'(i << 8);
            bus.in_pc    = 64'h1000 + 64'(4 * i);
            #1;
            if (i > 0) begin
                chk("t6_instr", 64'(bus.out_instr), 64'(32'hA000_0013 + 32'((i - 1) << 8)));
                chk("t6_pc", bus.out_pc, 64'h1000 + 64'(4 * (i - 1)));
            end
            tick();
        end
        bus.in_valid = 1'b0; #1;
        chk("t6_last", 64'(bus.out_instr), 64'(32'hA000_0013 + 32'(9 << 8)));
        chk("t6_occ1", 64'(occupancy), 1);
        tick(); bus.out_ready = 1'b0; #1;
        chk("t6_empty", 64'(occupancy), 0);

        // Reset mid-stream clears queue and counter
        push(32'h00100013, 64'h600);
        push(32'h00200013, 64'h604);
        reset = 1'b1; tick(); reset = 1'b0; #1;
        chk("t6_rst_occ", 64'(occupancy), 0);
        chk("t6_rst_stall", stall_cnt, 0);
        chk("t6_rst_valid", 64'(bus.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
